// File: rtl/fsk_tone_generator_if.sv
// rtl/fsk_tone_generator_if.sv - bit handshake, tone configuration and status bundle for fsk_tone_generator
interface fsk_tone_generator_if;
    logic        enable;
    logic        bit_data;
    logic        bit_valid;
    logic        bit_ready;
    logic [31:0] f0_half_period;
    logic [31:0] f1_half_period;
    logic        sample_data;
    logic        busy;
    logic [31:0] symbols_sent;

    modport master (
        output enable, bit_data, bit_valid, f0_half_period, f1_half_period,
        input  bit_ready, sample_data, busy, symbols_sent
    );

    modport slave (
        input  enable, bit_data, bit_valid, f0_half_period, f1_half_period,
        output bit_ready, sample_data, busy, symbols_sent
    );
endinterface

// File: rtl/fsk_tone_generator.sv
// rtl/fsk_tone_generator.sv - two-tone FSK square-wave generator, one symbol of CYCLES_PER_BIT periods per bit
// Optional FSK_IDLE_CARRIER_EN: emit the bit-0 tone while idle instead of holding the line low.
module fsk_tone_generator #(
    parameter int unsigned CLOCK_FREQUENCY    = 100000000,
    parameter int unsigned DEFAULT_FREQUENCY0 = 5000,
    parameter int unsigned DEFAULT_FREQUENCY1 = 10000,
    parameter int unsigned CYCLES_PER_BIT     = 4
) (
    input  logic clock,
    input  logic clear,
    fsk_tone_generator_if.slave bus
);

    localparam logic [31:0] HP0_RAW  = 32'(CLOCK_FREQUENCY / (2 * DEFAULT_FREQUENCY0));
    localparam logic [31:0] HP1_RAW  = 32'(CLOCK_FREQUENCY / (2 * DEFAULT_FREQUENCY1));
    localparam logic [31:0] HP0      = (HP0_RAW == 32'd0) ? 32'd1 : HP0_RAW;
    localparam logic [31:0] HP1      = (HP1_RAW == 32'd0) ? 32'd1 : HP1_RAW;
    localparam logic [31:0] LAST_PER = 32'(CYCLES_PER_BIT - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] TONE = 1'b1;

    logic [0:0]  state_q, state_d;
    logic        sample_q, sample_d;
    logic [31:0] half_cnt_q, half_cnt_d;
    logic [31:0] per_cnt_q, per_cnt_d;
    logic [31:0] hp_q, hp_d;
    logic [31:0] sent_q, sent_d;

    logic [31:0] hp0_eff, hp1_eff, hp_sel;
    logic        sym_end, ready, accept;

    always_comb begin
        hp0_eff = (bus.f0_half_period != 32'd0) ? bus.f0_half_period : HP0;
        hp1_eff = (bus.f1_half_period != 32'd0) ? bus.f1_half_period : HP1;
        hp_sel  = bus.bit_data ? hp1_eff : hp0_eff;
    end

    // Last cycle of a symbol: final low half of the final period has expired.
    assign sym_end = (state_q == TONE) && (half_cnt_q == 32'd0) && !sample_q
                     && (per_cnt_q == LAST_PER);
    assign ready   = !clear && bus.enable && ((state_q == IDLE) || sym_end);
    assign accept  = ready && bus.bit_valid;

    always_comb begin
        state_d    = state_q;
        sample_d   = sample_q;
        half_cnt_d = half_cnt_q;
        per_cnt_d  = per_cnt_q;
        hp_d       = hp_q;
        sent_d     = sent_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = TONE;
                    sample_d   = 1'b1;
                    half_cnt_d = hp_sel - 32'd1;
                    per_cnt_d  = 32'd0;
                    hp_d       = hp_sel;
                end else begin
`ifdef FSK_IDLE_CARRIER_EN
                    if (half_cnt_q != 32'd0) begin
                        half_cnt_d = half_cnt_q - 32'd1;
                    end else begin
                        sample_d   = !sample_q;
                        half_cnt_d = hp0_eff - 32'd1;
                    end
`else
                    sample_d   = 1'b0;
`endif
                end
            end
            TONE: begin
                if (half_cnt_q != 32'd0) begin
                    half_cnt_d = half_cnt_q - 32'd1;
                end else if (sample_q) begin
                    sample_d   = 1'b0;
                    half_cnt_d = hp_q - 32'd1;
                end else if (per_cnt_q != LAST_PER) begin
                    sample_d   = 1'b1;
                    per_cnt_d  = per_cnt_q + 32'd1;
                    half_cnt_d = hp_q - 32'd1;
                end else begin
                    sent_d = sent_q + 32'd1;
                    if (accept) begin
                        sample_d   = 1'b1;
                        half_cnt_d = hp_sel - 32'd1;
                        per_cnt_d  = 32'd0;
                        hp_d       = hp_sel;
                    end else begin
                        state_d    = IDLE;
                        sample_d   = 1'b0;
                        half_cnt_d = 32'd0;
                        per_cnt_d  = 32'd0;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                sample_d   = 1'b0;
                half_cnt_d = 32'd0;
                per_cnt_d  = 32'd0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q    <= IDLE;
            sample_q   <= 1'b0;
            half_cnt_q <= 32'd0;
            per_cnt_q  <= 32'd0;
            hp_q       <= 32'd0;
            sent_q     <= 32'd0;
        end else begin
            state_q    <= state_d;
            sample_q   <= sample_d;
            half_cnt_q <= half_cnt_d;
            per_cnt_q  <= per_cnt_d;
            hp_q       <= hp_d;
            sent_q     <= sent_d;
        end
    end

    assign bus.bit_ready    = ready;
    assign bus.sample_data  = sample_q;
    assign bus.busy         = (state_q == TONE);
    assign bus.symbols_sent = sent_q;

endmodule

// File: tb/tb_fsk_tone_generator.sv
// tb/tb_fsk_tone_generator.sv - directed self-checking bench for fsk_tone_generator
module tb_fsk_tone_generator;

    localparam int CPB = 4;

    logic clock;
    logic clear;
    int   n_checks;
    int   n_fail;
    int   exp_sent;

    fsk_tone_generator_if bus ();

    fsk_tone_generator #(
        .CLOCK_FREQUENCY   (110000),
        .DEFAULT_FREQUENCY0(5000),
        .DEFAULT_FREQUENCY1(10000),
        .CYCLES_PER_BIT    (CPB)
    ) dut (
        .clock(clock),
        .clear(clear),
        .bus  (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One symbol starting at the first negedge after the accepting edge.
    task automatic check_symbol(input string tag, input int hp, input logic ready_end,
                                input logic next_valid, input logic next_data, input int drop_en_at);
        int len;
        int werr;
        int berr;
        int rerr;
        len  = 2 * hp * CPB;
        werr = 0;
        berr = 0;
        rerr = 0;
        for (int k = 0; k < len; k++) begin
            @(negedge clock);
            if (bus.sample_data !== (((k / hp) % 2) == 0)) werr++;
            if (bus.busy !== 1'b1) berr++;
            if (bus.bit_ready !== ((k == len - 1) ? ready_end : 1'b0)) rerr++;
            if (k == 0) begin
                bus.bit_valid = next_valid;
                bus.bit_data  = next_data;
            end
            if (k == drop_en_at) bus.enable = 1'b0;
        end
        exp_sent++;
        check({tag, "_wave_err"}, 32'(werr), 32'd0);
        check({tag, "_busy_err"}, 32'(berr), 32'd0);
        check({tag, "_ready_err"}, 32'(rerr), 32'd0);
    endtask

    task automatic check_idle(input string tag);
        @(negedge clock);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_sent"}, bus.symbols_sent, 32'(exp_sent));
`ifndef FSK_IDLE_CARRIER_EN
        check({tag, "_sample"}, 32'(bus.sample_data), 32'd0);
`endif
    endtask

    initial begin
        int rerr;
        int serr;
        int cerr;
        int berr;
        logic prev;
        logic found;

        n_checks = 0;
        n_fail   = 0;
        exp_sent = 0;
        clear             = 1'b1;
        bus.enable        = 1'b0;
        bus.bit_valid     = 1'b1;
        bus.bit_data      = 1'b0;
        bus.f0_half_period = 32'd0;
        bus.f1_half_period = 32'd0;

        // Reset values, including bit_ready held low while clear is asserted.
        @(negedge clock);
        check("rst_sample", 32'(bus.sample_data), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_sent", bus.symbols_sent, 32'd0);
        bus.enable = 1'b1;
        #1;
        check("rst_ready", 32'(bus.bit_ready), 32'd0);
        bus.enable = 1'b0;
        @(negedge clock);
        clear = 1'b0;

        // Idle with enable low: nothing accepted.
        rerr = 0; serr = 0; cerr = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clock);
            if (bus.bit_ready !== 1'b0) rerr++;
`ifndef FSK_IDLE_CARRIER_EN
            if (bus.sample_data !== 1'b0) serr++;
`endif
            if (bus.symbols_sent !== 32'd0) cerr++;
        end
        check("idle_ready_err", 32'(rerr), 32'd0);
        check("idle_sample_err", 32'(serr), 32'd0);
        check("idle_sent_err", 32'(cerr), 32'd0);

        // Single bit 0 with runtime half-period 3.
        bus.f0_half_period = 32'd3;
        bus.f1_half_period = 32'd2;
        bus.bit_data  = 1'b0;
        bus.bit_valid = 1'b1;
        bus.enable    = 1'b1;
        #1;
        check("t2_ready_idle", 32'(bus.bit_ready), 32'd1);
        check_symbol("t2", 3, 1'b1, 1'b0, 1'b0, -1);
        check_idle("t2_end");

        // Gapless stream 0,1,1.
        bus.bit_data  = 1'b0;
        bus.bit_valid = 1'b1;
        check_symbol("t3a", 3, 1'b1, 1'b1, 1'b1, -1);
        check_symbol("t3b", 2, 1'b1, 1'b1, 1'b1, -1);
        check_symbol("t3c", 2, 1'b1, 1'b0, 1'b0, -1);
        check_idle("t3_end");

        // Elaborated defaults: 110000/10000 = 11, 110000/20000 = 5 (truncated).
        bus.f0_half_period = 32'd0;
        bus.f1_half_period = 32'd0;
        bus.bit_data  = 1'b0;
        bus.bit_valid = 1'b1;
        check_symbol("t4a", 11, 1'b1, 1'b1, 1'b1, -1);
        check_symbol("t4b", 5, 1'b1, 1'b0, 1'b0, -1);
        check_idle("t4_end");

        // enable dropped mid-symbol: symbol completes, held bit not taken.
        bus.f0_half_period = 32'd3;
        bus.f1_half_period = 32'd2;
        bus.bit_data  = 1'b0;
        bus.bit_valid = 1'b1;
        check_symbol("t5a", 3, 1'b0, 1'b1, 1'b0, 5);
        check_idle("t5a_end");
        berr = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (bus.busy !== 1'b0 || bus.bit_ready !== 1'b0) berr++;
        end
        check("t5a_no_accept_err", 32'(berr), 32'd0);

        // clear mid-symbol: immediate asynchronous abort.
        bus.enable    = 1'b1;
        bus.bit_data  = 1'b1;
        bus.bit_valid = 1'b1;
        @(negedge clock);
        bus.bit_valid = 1'b0;
        check("t5b_busy", 32'(bus.busy), 32'd1);
        repeat (4) @(negedge clock);
        check("t5b_sample_pre", 32'(bus.sample_data), 32'd1);
        #2;
        clear = 1'b1;
        #1;
        check("t5b_sample_async", 32'(bus.sample_data), 32'd0);
        check("t5b_busy_async", 32'(bus.busy), 32'd0);
        check("t5b_sent_async", bus.symbols_sent, 32'd0);
        @(negedge clock);
        clear = 1'b0;
        exp_sent = 0;

`ifdef FSK_IDLE_CARRIER_EN
        // Idle carrier at the bit-0 tone, then a bit-1 symbol starting high.
        bus.enable    = 1'b0;
        bus.bit_valid = 1'b0;
        bus.f0_half_period = 32'd3;
        bus.f1_half_period = 32'd2;
        @(negedge clock);
        prev  = bus.sample_data;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clock);
            if (bus.sample_data === 1'b1 && prev === 1'b0) found = 1'b1;
            prev = bus.sample_data;
        end
        check("t6_carrier_found", 32'(found), 32'd1);
        serr = 0;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clock);
            if (bus.sample_data !== (((k / 3) % 2) == 0)) serr++;
            if (bus.busy !== 1'b0 || bus.symbols_sent !== 32'd0) serr++;
        end
        check("t6_carrier_err", 32'(serr), 32'd0);
        bus.enable    = 1'b1;
        bus.bit_data  = 1'b1;
        bus.bit_valid = 1'b1;
        check_symbol("t6", 2, 1'b1, 1'b0, 1'b0, -1);
        check_idle("t6_end");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fsk_tone_generator.md
Name: fsk_tone_generator

Overview:
Transmit-side counterpart of frequency_analyzer. Converts a stream of data bits into a two-tone square wave on sample_data: bit 0 sends a tone at frequency 0 and bit 1 sends a tone at frequency 1. It drives the analyzer's sample_data input in loopback benches, and drives the line in the image-link transmitter.

Parameters:
CLOCK_FREQUENCY, 100000000, system clock in Hz; used only to compute the default half-periods.
DEFAULT_FREQUENCY0, 5000, tone frequency for bit 0 in Hz. Default half-period HP0 = CLOCK_FREQUENCY/(2*DEFAULT_FREQUENCY0) = 10000 cycles.
DEFAULT_FREQUENCY1, 10000, tone frequency for bit 1 in Hz. Default HP1 = 5000 cycles.
CYCLES_PER_BIT, 4, number of full output periods sent per bit (≥1).

Ports:
clock  input  1  system clock, rising edge.
clear  input  1  reset; asynchronous, active-high; clears all state.
enable  input  1  1 = new bits may be accepted.
bit_data  input  1  bit value offered.
bit_valid  input  1  bit_data is valid.
bit_ready  output  1  block can accept a bit this cycle.
f0_half_period  input  32  runtime half-period for bit 0, in clock cycles; 0 = use the default.
f1_half_period  input  32  runtime half-period for bit 1, in clock cycles; 0 = use the default.
sample_data  output  1  generated tone.
busy  output  1  a symbol is in progress.
symbols_sent  output  32  count of completed symbols.

Behaviour:
- Reset values (clear=1): sample_data=0, busy=0, bit_ready=0, symbols_sent=0, state=IDLE, all counters 0.
- States:
  - IDLE: bit_ready=enable.
  - TONE: bit_ready=enable only in the last cycle of the symbol; otherwise 0.
- Handshake: a bit is accepted on a rising edge where bit_valid && bit_ready.
- On accept:
  - Latch hp = (selected port != 0) ? port : default. The runtime port is f1_half_period when bit_data=1, else f0_half_period.
  - Port changes after accept are ignored until the next accept.
  - Next cycle: sample_data=1, busy=1, half_cnt=hp-1, per_cnt=0, state=TONE.
- Waveform: each period is a high half then a low half, each exactly hp cycles long.
- In TONE, each cycle with half_cnt≠0: half_cnt decrements.
- When half_cnt==0:
  - End of high half: sample_data→0, reload hp-1.
  - End of low half with per_cnt<CYCLES_PER_BIT-1: sample_data→1, per_cnt+1, reload hp-1.
  - End of low half with per_cnt==CYCLES_PER_BIT-1: end of symbol. symbols_sent+1 (wraps 0xFFFFFFFF→0).
    - If a new bit is accepted in the same cycle: sample_data→1, latch the new hp, stay in TONE. The stream is gapless, with no idle cycle between symbols.
    - Otherwise: state→IDLE, busy→0, sample_data stays 0.
- Symbol length: exactly 2*hp*CYCLES_PER_BIT cycles from the first high cycle to the symbol-end edge.
- hp=1: the output toggles every cycle (clock/2).
- enable deasserted mid-symbol: the current symbol completes normally. No new bit is accepted, so the block returns to IDLE.
- bit_valid held while bit_ready=0: the bit is not consumed. The source must hold it.
- clear asserted mid-symbol: immediate abort to reset values. The partial symbol is not counted.
- Default half-periods are computed at elaboration as 32-bit integer division (truncating). Minimum effective hp is 1.

Optional Feature:
Macro: FSK_IDLE_CARRIER_EN.
- Defined: in IDLE, sample_data continuously outputs the bit-0 tone, using the same hp and the same high/low counters.
  - The carrier is not counted in symbols_sent, and busy stays 0.
  - On accept, the carrier phase is discarded and the symbol starts with a high half as specified above.
- Not defined: sample_data is held at 0 in IDLE.

Test Plan:
1. Reset and idle: clear=1 for 20 ns, then 0 with enable=0 and bit_valid=1 → bit_ready=0, sample_data=0, symbols_sent=0 throughout 1000 cycles.
2. Single bit, runtime periods: f0_half_period=3, CYCLES_PER_BIT=4, enable=1, send bit 0.
   - Expect 4 periods of 3 high / 3 low (24 cycles total), then IDLE.
   - Expect busy low and symbols_sent=1.
3. Back-to-back bits: f0_half_period=3, f1_half_period=2, stream 0,1,1 with bit_valid held.
   - Expect a gapless 24+16+16 = 56-cycle waveform.
   - Expect bit_ready pulses exactly at the symbol-end cycles; symbols_sent=3.
4. Defaults and loopback: ports=0, feed sample_data into frequency_analyzer, send bits 0 then 1.
   - Expect half-periods of 10000 and then 5000 cycles.
   - Expect analyzer f0_value≈5000 Hz and f1_value≈10000 Hz within deviation 10.
5. Aborts:
   - Deassert enable mid-symbol → the symbol completes and no further bit is accepted.
   - Assert clear mid-symbol → sample_data=0 asynchronously and symbols_sent unchanged (0 if first).
6. With FSK_IDLE_CARRIER_EN, f0_half_period=3:
   - Idle output toggles every 3 cycles and symbols_sent stays 0.
   - Sending bit 1 (hp 2) starts with a high half of exactly 2 cycles.
